// File: rtl/data_mem_param.sv
// data_mem_param: stall-based data memory for the RV32I MEM stage.
// A single-port word RAM of DEPTH words plus one memory-mapped LED register.
// Byte/half stores use read-modify-write. Misaligned or unmapped accesses raise
// access_err and leave RAM and LED untouched.
//
// Ports:
//   clk         in   clock, all state on rising edge
//   reset_n     in   asynchronous active-low reset
//   addr        in   byte address
//   write_data  in   right-aligned store data
//   memwrite    in   store request (wins over memread)
//   memread     in   load request
//   sign_mask   in   [2]=word, [1]=half, else byte; [3]=sign-extend loads
//   read_data   out  formatted load result, valid in DONE, held until next accept
//   led         out  LED register
//   clk_stall   out  core must freeze (combinational from state and request)
//   access_err  out  last access was misaligned or unmapped
module data_mem_param #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] LED_ADDR  = 32'h0000_2000,
    parameter int unsigned LED_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [31:0]          addr,
    input  logic [31:0]          write_data,
    input  logic                 memwrite,
    input  logic                 memread,
    input  logic [3:0]           sign_mask,
    output logic [31:0]          read_data,
    output logic [LED_WIDTH-1:0] led,
    output logic                 clk_stall,
    output logic                 access_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RMW  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state, w_next;

    logic [31:0]          r_mem [DEPTH];
    logic [31:0]          r_word_buf;
    logic [AW-1:0]        r_idx;
    logic [1:0]           r_off;
    logic [15:0]          r_wdata;
    logic                 r_word;
    logic                 r_half;
    logic                 r_sign;
    logic                 r_store;
    logic                 r_err;
    logic                 r_led_hit;
    logic [LED_WIDTH-1:0] r_led;

    // Request-side decode, used on the accept edge
    logic          w_req;
    logic          w_accept;
    logic          w_in_ram_hit;
    logic          w_in_led_hit;
    logic          w_in_word;
    logic          w_in_half;
    logic          w_in_mis;
    logic          w_in_err;
    logic [AW-1:0] w_in_idx;

    assign w_req        = memread | memwrite;
    assign w_accept     = (r_state == IDLE) & w_req;
    assign w_in_ram_hit = (addr[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign w_in_led_hit = (addr == LED_ADDR);
    assign w_in_word    = sign_mask[2];
    assign w_in_half    = ~sign_mask[2] & sign_mask[1];
    assign w_in_mis     = (w_in_half & addr[0]) | (w_in_word & (|addr[1:0]));
    assign w_in_err     = w_in_mis | ~(w_in_ram_hit | w_in_led_hit);
    assign w_in_idx     = addr[AW+1:2];

    // Sub-word merge of the buffered store into the buffered RAM word
    logic [31:0] w_merged;
    always_comb begin
        w_merged = r_word_buf;
        if (r_half) begin
            if (r_off[1]) begin
                w_merged[31:16] = r_wdata;
            end else begin
                w_merged[15:0] = r_wdata;
            end
        end else begin
            w_merged[{r_off, 3'b000} +: 8] = r_wdata[7:0];
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, stall and RAM write port
    logic          w_ram_we;
    logic [AW-1:0] w_ram_idx;
    logic [31:0]   w_ram_wdata;

    always_comb begin
        w_next      = r_state;
        clk_stall   = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_idx   = w_in_idx;
        w_ram_wdata = write_data;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    clk_stall = 1'b1;
                    w_next    = DONE;
                    if (memwrite && !w_in_err && w_in_ram_hit) begin
                        if (w_in_word) begin
                            w_ram_we = 1'b1;
                        end else begin
                            w_next = RMW;
                        end
                    end
                end
            end
            RMW: begin
                // Async reset here drops the state to IDLE before the edge, so no write
                clk_stall   = 1'b1;
                w_ram_we    = 1'b1;
                w_ram_idx   = r_idx;
                w_ram_wdata = w_merged;
                w_next      = DONE;
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // RAM array, contents are not reset
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_mem[w_ram_idx] <= w_ram_wdata;
        end
    end

    // Request buffers, word buffer and LED register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word_buf <= 32'd0;
            r_idx      <= '0;
            r_off      <= 2'd0;
            r_wdata    <= 16'd0;
            r_word     <= 1'b0;
            r_half     <= 1'b0;
            r_sign     <= 1'b0;
            r_store    <= 1'b0;
            r_err      <= 1'b0;
            r_led_hit  <= 1'b0;
            r_led      <= '0;
        end else if (w_accept) begin
            r_idx     <= w_in_idx;
            r_off     <= addr[1:0];
            r_wdata   <= write_data[15:0];
            r_word    <= w_in_word;
            r_half    <= w_in_half;
            r_sign    <= sign_mask[3];
            r_store   <= memwrite;
            r_err     <= w_in_err;
            r_led_hit <= w_in_led_hit;
            if (w_in_ram_hit) begin
                r_word_buf <= r_mem[w_in_idx];
            end
            if (memwrite && !w_in_err && w_in_led_hit) begin
                r_led <= write_data[LED_WIDTH-1:0];
            end
        end
    end

    // Load formatting, decoded purely from registers so it holds until the next accept
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = 8'(r_word_buf >> {r_off, 3'b000});
    assign w_half = r_off[1] ? r_word_buf[31:16] : r_word_buf[15:0];

    always_comb begin
        read_data = 32'd0;
        if (r_store || r_err) begin
            read_data = 32'd0;
        end else if (r_led_hit) begin
            read_data = 32'(r_led);
        end else if (r_word) begin
            read_data = r_word_buf;
        end else if (r_half) begin
            read_data = {{16{r_sign & w_half[15]}}, w_half};
        end else begin
            read_data = {{24{r_sign & w_byte[7]}}, w_byte};
        end
    end

    assign led        = r_led;
    assign access_err = r_err;

endmodule

// File: tb/tb_data_mem_param.sv
// Scoreboard bench for data_mem_param: a byte-addressed reference model predicts
// each access; a negedge monitor pops and compares at every DONE cycle.
module tb_data_mem_param;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] LEDA  = 32'h0000_2000;
    localparam int unsigned LW    = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [31:0]   addr = 32'd0;
    logic [31:0]   write_data = 32'd0;
    logic          memwrite = 1'b0;
    logic          memread = 1'b0;
    logic [3:0]    sign_mask = 4'd0;
    logic [31:0]   read_data;
    logic [LW-1:0] led;
    logic          clk_stall;
    logic          access_err;

    data_mem_param #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE),
        .LED_ADDR  (LEDA),
        .LED_WIDTH (LW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .addr       (addr),
        .write_data (write_data),
        .memwrite   (memwrite),
        .memread    (memread),
        .sign_mask  (sign_mask),
        .read_data  (read_data),
        .led        (led),
        .clk_stall  (clk_stall),
        .access_err (access_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   rd;
        logic          err;
        logic [LW-1:0] led;
        int            stalls;
    } exp_t;

    exp_t          sb_q[$];
    int            checks = 0;
    int            failures = 0;
    logic [7:0]    m_bytes [4*DEPTH];
    logic [LW-1:0] m_led = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: byte-array memory, size from mask, little-endian assembly
    task automatic model(input logic [31:0] a, input logic [31:0] wd, input bit wr,
                         input logic [3:0] m, output exp_t e);
        int          sz;
        logic [31:0] off;
        logic [31:0] v;
        bit          ram;
        bit          ledh;
        bit          err;
        sz   = m[2] ? 4 : (m[1] ? 2 : 1);
        off  = a - BASE;
        ram  = off < 32'(4*DEPTH);
        ledh = (a == LEDA);
        err  = ((a & 32'(sz - 1)) != 0) || !(ram || ledh);
        e.stalls = (wr && !err && ram && sz < 4) ? 2 : 1;
        if (wr && !err) begin
            if (ram) begin
                for (int i = 0; i < sz; i++) m_bytes[off + 32'(i)] = 8'(wd >> (8*i));
            end else begin
                m_led = wd[LW-1:0];
            end
        end
        v = 32'd0;
        if (!wr && !err) begin
            if (ledh) begin
                v = 32'(m_led);
            end else begin
                for (int i = 0; i < sz; i++) v = v | (32'(m_bytes[off + 32'(i)]) << (8*i));
                if (m[3] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
            end
        end
        e.rd  = v;
        e.err = err;
        e.led = m_led;
    endtask

    task automatic access(input logic [31:0] a, input logic [31:0] wd,
                          input bit rd, input bit wr, input logic [3:0] m);
        exp_t e;
        int   n;
        model(a, wd, wr, m, e);
        sb_q.push_back(e);
        addr = a; write_data = wd; memread = rd; memwrite = wr; sign_mask = m;
        @(posedge clk); #1;
        n = 0;
        while (clk_stall && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_within_budget", 32'(n < 8), 32'd1);
        @(posedge clk); #1;
        memread = 1'b0; memwrite = 1'b0;
    endtask

    // Monitor: a falling clk_stall marks the DONE cycle of an access
    exp_t mon_e;
    bit   mon_prev = 1'b0;
    int   mon_cnt = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mon_prev = 1'b0;
                mon_cnt  = 0;
            end else begin
                if (clk_stall) begin
                    mon_cnt++;
                end else if (mon_prev) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done actual=done required=no_access at %0t", $time);
                    end else begin
                        mon_e = sb_q.pop_front();
                        chk("read_data",  read_data,         mon_e.rd);
                        chk("access_err", 32'(access_err),   32'(mon_e.err));
                        chk("led",        32'(led),          32'(mon_e.led));
                        chk("stall_cyc",  32'(mon_cnt),      32'(mon_e.stalls));
                    end
                    mon_cnt = 0;
                end
                mon_prev = clk_stall;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra;
        logic [3:0]  rm;
        int          sel;
        int          op;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_read_data",  read_data,        32'd0);
        chk("rst_access_err", 32'(access_err),  32'd0);
        chk("rst_clk_stall",  32'(clk_stall),   32'd0);
        chk("rst_led",        32'(led),         32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Known contents for the low window
        for (int w = 0; w < 16; w++) access(32'(w*4), $urandom, 1'b0, 1'b1, 4'b0100);

        access(32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1, 4'b0100);
        access(32'h10, 32'h0,         1'b1, 1'b0, 4'b0100);
        access(32'h13, 32'h7F,        1'b0, 1'b1, 4'b0000);
        access(32'h10, 32'h0,         1'b1, 1'b0, 4'b0100);
        access(32'h12, 32'h0,         1'b1, 1'b0, 4'b1000);
        access(32'h12, 32'h0,         1'b1, 1'b0, 4'b0000);
        access(32'h16, 32'h8001,      1'b0, 1'b1, 4'b0010);
        access(32'h16, 32'h0,         1'b1, 1'b0, 4'b1010);
        access(32'h16, 32'h0,         1'b1, 1'b0, 4'b0010);
        access(LEDA,   32'h0000_00A5, 1'b0, 1'b1, 4'b0100);
        access(LEDA,   32'h0,         1'b1, 1'b0, 4'b0100);
        access(LEDA & 32'(4*DEPTH - 1), 32'h0, 1'b1, 1'b0, 4'b0100);
        access(32'h11, 32'h0,         1'b1, 1'b0, 4'b1010);
        access(32'h12, 32'h1234_5678, 1'b0, 1'b1, 4'b0100);
        access(32'h10, 32'h0,         1'b1, 1'b0, 4'b0100);
        access(32'(4*DEPTH), 32'h0,   1'b1, 1'b0, 4'b0100);
        access(32'h10, 32'h0,         1'b1, 1'b0, 4'b0100);
        access(32'h14, 32'h5555_AAAA, 1'b1, 1'b1, 4'b0100);
        access(32'h14, 32'h0,         1'b1, 1'b0, 4'b0100);

        // Reset during the RMW cycle of a byte store: no write, LED cleared
        access(32'h20, 32'h0123_4567, 1'b0, 1'b1, 4'b0100);
        addr = 32'h20; write_data = 32'h11; memread = 1'b0; memwrite = 1'b1; sign_mask = 4'b0000;
        @(posedge clk); #1;
        chk("rmw_stall", 32'(clk_stall), 32'd1);
        reset_n = 1'b0;
        memwrite = 1'b0;
        #1;
        chk("rmw_rst_stall",      32'(clk_stall),  32'd0);
        chk("rmw_rst_led",        32'(led),        32'd0);
        chk("rmw_rst_read_data",  read_data,       32'd0);
        chk("rmw_rst_access_err", 32'(access_err), 32'd0);
        m_led = '0;
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        access(32'h20, 32'h0, 1'b1, 1'b0, 4'b0100);

        // Randomized traffic over the window, LED and unmapped addresses
        for (int k = 0; k < 300; k++) begin
            sel = int'($urandom_range(0, 19));
            op  = int'($urandom_range(0, 2));
            rm  = {1'($urandom_range(0, 1)), 3'b000};
            case ($urandom_range(0, 2))
                0:       rm[1] = 1'b1;
                1:       rm[2] = 1'b1;
                default: rm[0] = 1'b0;
            endcase
            if (sel < 16) begin
                ra = 32'($urandom_range(0, 63));
                if ($urandom_range(0, 1) == 1) ra = rm[2] ? (ra & 32'hFFFF_FFFC)
                                                 : (rm[1] ? (ra & 32'hFFFF_FFFE) : ra);
            end else if (sel < 18) begin
                ra = LEDA;
            end else if (sel == 18) begin
                ra = 32'(4*DEPTH);
            end else begin
                ra = 32'(4*DEPTH) + 32'($urandom_range(0, 63));
            end
            access(ra, $urandom, op != 1, op != 0, rm);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_param.md
# data_mem_param

Parametrised data memory for the RV32I core: a single-port word RAM of configurable depth plus a memory-mapped LED register, with stall-based access to the core. Handles LB/LBU/LH/LHU/LW loads and SB/SH/SW stores. Sub-word stores use read-modify-write; word stores write directly. Misaligned and out-of-range accesses are reported on an error flag rather than silently corrupting memory. Sits between the core's MEM stage and block RAM; the core freezes its pipeline while `clk_stall` is high.

## Interface
- `DEPTH`, 1024: RAM size in 32-bit words; power of two, ≥ 4. `AW = $clog2(DEPTH)`.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to `4*DEPTH`.
- `LED_ADDR`, 32'h0000_2000: byte address of the LED register; word-aligned and outside the RAM range.
- `LED_WIDTH`, 8: LED register width, 1..32.

Ports:
- `clk` in 1: clock. One clock, all state on rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `addr` in 32: byte address.
- `write_data` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `memwrite` in 1: store request.
- `memread` in 1: load request.
- `sign_mask` in 4: access type.
  - [2]=1: word.
  - else [1]=1: halfword.
  - else: byte.
  - [3]=1: sign-extend loads.
- `read_data` out 32: load result, extended per `sign_mask`.
- `led` out LED_WIDTH: LED register.
- `clk_stall` out 1: core must hold its state and request inputs.
- `access_err` out 1: last access was misaligned or unmapped.

## Operation
- States: IDLE, RMW, DONE.
- Request = `memread | memwrite`, sampled only in IDLE. In RMW and DONE, inputs are ignored.
- If both `memread` and `memwrite` are high, the access is a store; `read_data` = 0.
- On the IDLE accept edge, latch `addr`, `write_data`, `sign_mask`, and op into buffers. Decode from the buffers:
  - RAM hit: `addr[31:AW+2] == BASE_ADDR[31:AW+2]`, index `addr[AW+1:2]`.
  - LED hit: `addr == LED_ADDR`.
  - Misaligned: half at `addr[0]=1`, or word at `addr[1:0]≠0`.
  - Error = misaligned, or neither RAM nor LED hit.
- Load, or error: read `RAM[index]` into `word_buf` (RAM hit only). → DONE.
- Word store to RAM: write `RAM[index]` directly. → DONE.
- Byte/half store to RAM: read `RAM[index]` into `word_buf`. → RMW.
  - RMW: merge the store bytes into the `addr[1:0]`-selected lane(s) of `word_buf`, write RAM. → DONE.
- LED store (aligned, any width): `led <= write_data[LED_WIDTH-1:0]`. → DONE.
- LED load: `read_data` = `{0, led}`, never sign-extended.
- Error access: no RAM or LED write. `read_data` = 0. `access_err` = 1 during DONE and held until the next accept.
- DONE: `clk_stall` = 0; `read_data` is valid. → IDLE unconditionally. The core advances at the end of this cycle.
- Load formatting (combinational from `word_buf`, buffered offset and mask):
  - byte: lane `addr[1:0]`.
  - half: lane pair `addr[1]`.
  - word: full 32 bits.
  - Zero- or sign-extend per `sign_mask[3]`.
- `read_data` and `access_err` hold their values from DONE until the next accept.

## Timing
- `clk_stall = (state==IDLE & request) | (state==RMW)`. It is combinational from state and inputs.
- Accept edge to DONE:
  - load, word store, LED access, or error: 1 stall cycle.
  - sub-word RAM store: 2 stall cycles.
- Back-to-back requests: minimum period is 2 cycles (load) and 3 cycles (sub-word store), counting the DONE cycle.
- Reset values: state IDLE; `led` = 0; `word_buf` = 0; `read_data` = 0; `access_err` = 0; `clk_stall` = 0 while no request is present. RAM contents are not reset.
- Reset asserted in RMW: the merged write is not performed and the FSM returns to IDLE. RAM keeps its pre-store contents.
- A word store and a load to the same index in consecutive requests: the load returns the new data. No forwarding is needed because the write completes before DONE.
- Highest RAM address is `BASE_ADDR + 4*DEPTH - 4`. `BASE_ADDR + 4*DEPTH` is unmapped (error), unless it equals `LED_ADDR`.

## Test plan
- Reset, then SW 0xDEADBEEF @0x10, then LW @0x10.
  - `clk_stall` high 1 cycle per access.
  - `read_data` = 0xDEADBEEF in the load's DONE cycle.
- SB 0x7F @0x13 over 0xDEADBEEF.
  - 2 stall cycles.
  - LW @0x10 → 0x7FADBEEF.
  - LB @0x12 → 0xFFFFFFAD; LBU @0x12 → 0x000000AD.
- SH 0x8001 @0x16, then LH @0x16 → 0xFFFF8001 and LHU @0x16 → 0x00008001.
- SW 0x000000A5 @LED_ADDR.
  - `led` = 0xA5 after the accept edge.
  - LW @LED_ADDR → 0x000000A5.
  - RAM word at `LED_ADDR`'s RAM alias is unchanged.
- Misaligned and unmapped accesses:
  - LH @0x11 → `access_err` = 1 and `read_data` = 0.
  - SW @0x12 → `access_err` = 1; RAM @0x10 is unchanged.
  - LW @`4*DEPTH` → `access_err` = 1.
  - The next valid access clears `access_err`.
- Assert `reset_n` low in the RMW cycle of SB 0x11 @0x20 (old word 0x01234567).
  - FSM returns to IDLE and `led` = 0.
  - LW @0x20 → 0x01234567.
- Also check: simultaneous `memread` and `memwrite` performs the store only.
